bcd2_7seg_scan: RTL

Display-side consumer for the two-digit BCD up/down counter (00–99). Registers the 8-bit BCD `Count` bus and time-multiplexes it onto a two-digit, common-anode 7-segment display. Flags illegal BCD and pulses on every 99↔00 wrap so the rest of the design can observe the counter end to end. Sits between the counter and the board display pins, in the same `Clk` domain.

---
 rtl/bcd7_pkg.sv | 33 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/bcd2_7seg_scan.sv | 93 +++++++++
 3 files changed

// File: rtl/bcd7_pkg.sv
// Shared constants and types for the two-digit BCD 7-segment scanner.
// Segment codes are active low, ordered {g,f,e,d,c,b,a}.
package bcd7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } digit_sel_e;

    function automatic logic bcd_illegal(input logic [7:0] value);
        return (value[7:4] > BCD_MAX) || (value[3:0] > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles render as the error glyph E.
module bcd_to_7seg
    import bcd7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd2_7seg_scan.sv
// Two-digit common-anode scanner for the BCD up/down counter: captures Count,
// multiplexes the digits, flags illegal BCD and pulses on 99<->00 wraps.
module bcd2_7seg_scan
    import bcd7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Count,
    output logic [6:0] Seg,
    output logic [1:0] An,
    output logic       Err,
    output logic       Wrap
);

    localparam int                DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [7:0]       cnt_q;
    logic [DIV_W-1:0] div;
    digit_sel_e       state, state_d;
    logic             live, live_d;
    logic             tick;
    logic             err_d;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;

    bcd_to_7seg u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Outputs are built from the next state so An and Seg flip on the same
    // edge as the digit-select state, keeping every slot REFRESH_DIV long.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned and infers a latch.
        tick    = (div == DIV_LAST);
        state_d = state;
        live_d  = live;
        seg_d   = SEG_BLANK;
        an_d    = AN_OFF;

        if (tick) begin
            state_d = (state == ONES) ? TENS : ONES;
            live_d  = 1'b1;
        end

        err_d  = bcd_illegal(cnt_q);
        nibble = (state_d == TENS) ? cnt_q[7:4] : cnt_q[3:0];

        if (live_d) begin
            an_d = (state_d == TENS) ? AN_TENS : AN_ONES;
            if (err_d)
                seg_d = SEG_E;
            else if (LZ_BLANK && state_d == TENS && cnt_q[7:4] == 4'd0)
                seg_d = SEG_BLANK;
            else
                seg_d = dec_seg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= 8'h00;
            div   <= '0;
            state <= ONES;
            live  <= 1'b0;
            Seg   <= SEG_BLANK;
            An    <= AN_OFF;
            Err   <= 1'b0;
            Wrap  <= 1'b0;
        end else begin
            cnt_q <= Count;
            div   <= tick ? '0 : div + DIV_W'(1);
            state <= state_d;
            live  <= live_d;
            Seg   <= seg_d;
            An    <= an_d;
            Err   <= err_d;
            // Compared against the incoming Count, so Wrap lands one edge after it.
            Wrap  <= (cnt_q == 8'h99 && Count == 8'h00) ||
                     (cnt_q == 8'h00 && Count == 8'h99);
        end
    end

endmodule
